// File: rtl/ava_pkg.sv
// Shared AVA video types and constants.
// Holds the VRAM geometry plus the return-owner type used by the
// VRAM arbiter (ava_vram_arbiter).
package ava_pkg;

  localparam int VRAM_ADDR_WIDTH = 16;
  localparam int VRAM_BE_WIDTH   = 4;
  localparam int VRAM_DATA_WIDTH = 32;

  // Which requester the VRAM read data returning next cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2
  } vram_owner_t;

  // Owner of the read data that will return one cycle after this grant.
  // A CPU write or an idle cycle returns nothing.
  function automatic vram_owner_t read_owner(input logic disp_gnt,
                                             input logic cpu_gnt,
                                             input logic cpu_we);
    vram_owner_t own;
    own = OWN_NONE;
    if (disp_gnt) begin
      own = OWN_DISP;
    end else if (cpu_gnt && !cpu_we) begin
      own = OWN_CPU;
    end
    return own;
  endfunction

endpackage

// File: rtl/ava_vram_arbiter_if.sv
// Bundle of the display, CPU and VRAM-macro signals around the VRAM arbiter.
// slave  : the arbiter's view.
// master : the view of the surrounding logic (display, CPU bus, VRAM macro).
interface ava_vram_arbiter_if;
  import ava_pkg::*;

  // display pixel-fetch side
  logic                       disp_req;
  logic [VRAM_ADDR_WIDTH-1:0] disp_addr;
  logic                       disp_gnt;
  logic                       disp_rvalid;
  logic [VRAM_DATA_WIDTH-1:0] disp_rdata;

  // CPU bus side
  logic                       cpu_req;
  logic                       cpu_we;
  logic [VRAM_ADDR_WIDTH-1:0] cpu_addr;
  logic [VRAM_DATA_WIDTH-1:0] cpu_wdata;
  logic [VRAM_BE_WIDTH-1:0]   cpu_be;
  logic                       cpu_gnt;
  logic                       cpu_rvalid;
  logic [VRAM_DATA_WIDTH-1:0] cpu_rdata;

  // VRAM macro port
  logic [VRAM_ADDR_WIDTH-1:0] vram_a;
  logic                       vram_we;
  logic [VRAM_BE_WIDTH-1:0]   vram_be;
  logic [VRAM_DATA_WIDTH-1:0] vram_wd;
  logic [VRAM_DATA_WIDTH-1:0] vram_d;

  modport slave (
    input  disp_req, disp_addr,
    output disp_gnt, disp_rvalid, disp_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output vram_a, vram_we, vram_be, vram_wd,
    input  vram_d
  );

  modport master (
    output disp_req, disp_addr,
    input  disp_gnt, disp_rvalid, disp_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  vram_a, vram_we, vram_be, vram_wd,
    output vram_d
  );

endinterface

// File: rtl/ava_starve_guard.sv
// CPU starvation guard for the VRAM arbiter.
// Counts consecutive cycles in which the CPU requests but is denied; once
// the count reaches STARVE_LIMIT the CPU is forced through on the next access.
module ava_starve_guard #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic cpu_gnt,
  output logic force_cpu
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_q;
  logic [7:0] starve_next;

  // Count denied CPU cycles, saturate at the limit, restart on grant or idle.
  always_comb begin
    starve_next = starve_q;
    if (!cpu_req || cpu_gnt) begin
      starve_next = 8'd0;
    end else if (starve_q != LIMIT) begin
      starve_next = starve_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= 8'd0;
    end else begin
      starve_q <= starve_next;
    end
  end

  assign force_cpu = (starve_q == LIMIT);

endmodule

// File: rtl/ava_vram_arbiter.sv
// Single-port VRAM arbiter between the display pixel fetch and the CPU bus.
// The display wins by default; the VRAM macro returns read data one cycle
// after the address, and owner_q steers the matching rvalid.
// Optional starvation guard: define AVA_VRAM_STARVE_GUARD_EN.
module ava_vram_arbiter
  import ava_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               reset,
  ava_vram_arbiter_if.slave bus
);

  logic                       force_cpu;
  logic                       disp_gnt;
  logic                       cpu_gnt;
  logic                       cpu_wr;
  vram_owner_t                owner_q;
  vram_owner_t                owner_next;
  logic [VRAM_ADDR_WIDTH-1:0] addr_hold_q;
  logic [VRAM_ADDR_WIDTH-1:0] vram_a_mux;

`ifdef AVA_VRAM_STARVE_GUARD_EN
  ava_starve_guard #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_guard (
    .clk      (clk),
    .reset    (reset),
    .cpu_req  (bus.cpu_req),
    .cpu_gnt  (cpu_gnt),
    .force_cpu(force_cpu)
  );
`else
  // Strict display priority: the CPU is never forced through.
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT == 0);
  assign force_cpu = 1'b0;
`endif

  // Winner selection: display first unless the guard forces the CPU;
  // nothing is granted while reset is held.
  always_comb begin
    disp_gnt = 1'b0;
    cpu_gnt  = 1'b0;
    if (!reset) begin
      if (bus.cpu_req && (force_cpu || !bus.disp_req)) begin
        cpu_gnt = 1'b1;
      end else if (bus.disp_req) begin
        disp_gnt = 1'b1;
      end
    end
  end

  assign cpu_wr = cpu_gnt & bus.cpu_we;

  // VRAM port mux: winner's address, or the previous address when idle.
  always_comb begin
    vram_a_mux = addr_hold_q;
    if (disp_gnt) begin
      vram_a_mux = bus.disp_addr;
    end else if (cpu_gnt) begin
      vram_a_mux = bus.cpu_addr;
    end
  end

  // Remember the last driven address so an idle cycle keeps vram_a stable.
  always_ff @(posedge clk) begin
    addr_hold_q <= vram_a_mux;
  end

  // Next return owner from this cycle's grant.
  always_comb begin
    owner_next = read_owner(disp_gnt, cpu_gnt, bus.cpu_we);
  end

  // Return-owner register; reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_next;
    end
  end

  // Drive the bus outputs; read data is shared, only the owner's rvalid fires.
  always_comb begin
    bus.disp_gnt    = disp_gnt;
    bus.cpu_gnt     = cpu_gnt;
    bus.vram_a      = vram_a_mux;
    bus.vram_we     = cpu_wr;
    bus.vram_be     = cpu_wr ? bus.cpu_be : '0;
    bus.vram_wd     = bus.cpu_wdata;
    bus.disp_rdata  = bus.vram_d;
    bus.cpu_rdata   = bus.vram_d;
    bus.disp_rvalid = !reset && (owner_q == OWN_DISP);
    bus.cpu_rvalid  = !reset && (owner_q == OWN_CPU);
  end

endmodule

// File: tb/tb_ava_vram_arbiter.sv
// Directed bench for ava_vram_arbiter with a behavioural VRAM macro and a
// read-return scoreboard. Build with AVA_VRAM_STARVE_GUARD_EN to exercise
// the starvation guard (limit 3) instead of strict display priority.
module tb_ava_vram_arbiter;
  import ava_pkg::*;

  typedef struct {
    vram_owner_t own;
    logic [31:0] data;
    int          due;
  } sb_entry_t;

  logic clk;
  logic reset;
  int   cyc_n;
  int   n_pass;
  int   n_total;

  logic [31:0] vmem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] rd_q;
  logic [15:0] last_a;
  logic        last_a_known;
  sb_entry_t   sb [$];

  ava_vram_arbiter_if bus ();

  ava_vram_arbiter #(
    .STARVE_LIMIT(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Behavioural VRAM macro: byte-enabled write, one-cycle registered read.
  always @(posedge clk) begin
    if (bus.vram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.vram_be[b]) vmem[bus.vram_a[7:0]][8*b +: 8] <= bus.vram_wd[8*b +: 8];
      end
    end
    rd_q <= vmem[bus.vram_a[7:0]];
  end
  assign bus.vram_d = rd_q;

  function automatic logic [31:0] init_word(input int i);
    return 32'h5A000000 ^ (32'(i) * 32'h00010101);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle: check grants, VRAM port and returned reads against the
  // expected winner, update the scoreboard, then step to just after the edge.
  task automatic cyc(input logic edg, input logic ecg, input string tag);
    sb_entry_t   e;
    logic        exp_dv;
    logic        exp_cv;
    logic [31:0] exp_d;
    logic        exp_we;
    logic [15:0] exp_a;
    @(negedge clk);
    exp_dv = 1'b0;
    exp_cv = 1'b0;
    exp_d  = 32'h0;
    if (sb.size() > 0 && sb[0].due == cyc_n) begin
      e      = sb.pop_front();
      exp_dv = (e.own == OWN_DISP);
      exp_cv = (e.own == OWN_CPU);
      exp_d  = e.data;
    end
    chk({tag, ".disp_gnt"}, 32'(bus.disp_gnt), 32'(edg));
    chk({tag, ".cpu_gnt"}, 32'(bus.cpu_gnt), 32'(ecg));
    exp_we = ecg & bus.cpu_we;
    chk({tag, ".vram_we"}, 32'(bus.vram_we), 32'(exp_we));
    chk({tag, ".vram_be"}, 32'(bus.vram_be), exp_we ? 32'(bus.cpu_be) : 32'h0);
    chk({tag, ".disp_rvalid"}, 32'(bus.disp_rvalid), 32'(exp_dv));
    chk({tag, ".cpu_rvalid"}, 32'(bus.cpu_rvalid), 32'(exp_cv));
    if (exp_dv) chk({tag, ".disp_rdata"}, bus.disp_rdata, exp_d);
    if (exp_cv) chk({tag, ".cpu_rdata"}, bus.cpu_rdata, exp_d);
    exp_a = edg ? bus.disp_addr : (ecg ? bus.cpu_addr : last_a);
    if (edg || ecg || last_a_known) chk({tag, ".vram_a"}, 32'(bus.vram_a), 32'(exp_a));
    if (exp_we) chk({tag, ".vram_wd"}, bus.vram_wd, bus.cpu_wdata);
    if (edg || ecg) begin
      last_a       = exp_a;
      last_a_known = 1'b1;
    end
    if (edg) begin
      sb.push_back('{own: OWN_DISP, data: ref_mem[bus.disp_addr[7:0]], due: cyc_n + 1});
    end else if (ecg && !bus.cpu_we) begin
      sb.push_back('{own: OWN_CPU, data: ref_mem[bus.cpu_addr[7:0]], due: cyc_n + 1});
    end else if (ecg) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.cpu_be[b]) ref_mem[bus.cpu_addr[7:0]][8*b +: 8] = bus.cpu_wdata[8*b +: 8];
      end
    end
    $display("cyc %0d %s: disp_gnt=%0b cpu_gnt=%0b disp_rv=%0b cpu_rv=%0b vram_a=%h",
             cyc_n, tag, bus.disp_gnt, bus.cpu_gnt, bus.disp_rvalid, bus.cpu_rvalid, bus.vram_a);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    cyc_n        = 0;
    last_a       = 16'h0;
    last_a_known = 1'b0;
    for (int i = 0; i < 256; i++) begin
      vmem[i]    = init_word(i);
      ref_mem[i] = init_word(i);
    end
    reset         = 1'b1;
    bus.disp_req  = 1'b1;
    bus.disp_addr = 16'h0003;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 16'h0004;
    bus.cpu_wdata = 32'h12345678;
    bus.cpu_be    = 4'hF;
    @(posedge clk);
    #1;

    // Reset: requests present, but nothing issued.
    cyc(1'b0, 1'b0, "reset0");
    cyc(1'b0, 1'b0, "reset1");
    reset        = 1'b0;
    bus.disp_req = 1'b0;
    bus.cpu_req  = 1'b0;
    cyc(1'b0, 1'b0, "idle0");

    // CPU-only write with partial byte enables.
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 16'h0010;
    bus.cpu_wdata = 32'hDEADBEEF;
    bus.cpu_be    = 4'b0101;
    cyc(1'b0, 1'b1, "cpu_wr");
    bus.cpu_req = 1'b0;
    cyc(1'b0, 1'b0, "after_wr");

    // Back-to-back display reads.
    bus.disp_req = 1'b1;
    for (int a = 0; a < 3; a++) begin
      bus.disp_addr = 16'(a);
      cyc(1'b1, 1'b0, $sformatf("disp_rd%0d", a));
    end
    bus.disp_req = 1'b0;
    cyc(1'b0, 1'b0, "disp_tail");

    // CPU read of the partially written word.
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h0010;
    cyc(1'b0, 1'b1, "cpu_rd10");
    bus.cpu_req = 1'b0;
    cyc(1'b0, 1'b0, "cpu_rd10_tail");

    // Contention: display streaming while the CPU waits to read.
    bus.disp_req  = 1'b1;
    bus.disp_addr = 16'h0030;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 16'h0031;
`ifdef AVA_VRAM_STARVE_GUARD_EN
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("starve_q r%0d k%0d", r, k), 32'(dut.u_starve_guard.starve_q), 32'(k));
        cyc(1'b1, 1'b0, $sformatf("guard_d r%0d", r));
      end
      chk($sformatf("starve_q r%0d full", r), 32'(dut.u_starve_guard.starve_q), 32'd3);
      cyc(1'b0, 1'b1, $sformatf("guard_c r%0d", r));
    end
    chk("starve_q cleared", 32'(dut.u_starve_guard.starve_q), 32'd0);
    bus.disp_req = 1'b0;
    bus.cpu_req  = 1'b0;
    cyc(1'b0, 1'b0, "guard_tail");
`else
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 1'b0, $sformatf("prio%0d", k));
    end
    bus.disp_req = 1'b0;
    cyc(1'b0, 1'b1, "cpu_after_disp");
    bus.cpu_req = 1'b0;
    cyc(1'b0, 1'b0, "prio_tail");
`endif

    // Alternating CPU (0x20) and display (0x21) reads.
    bus.cpu_addr  = 16'h0020;
    bus.cpu_we    = 1'b0;
    bus.disp_addr = 16'h0021;
    for (int k = 0; k < 3; k++) begin
      bus.cpu_req  = 1'b1;
      bus.disp_req = 1'b0;
      cyc(1'b0, 1'b1, $sformatf("alt_cpu%0d", k));
      bus.cpu_req  = 1'b0;
      bus.disp_req = 1'b1;
      cyc(1'b1, 1'b0, $sformatf("alt_disp%0d", k));
    end
    bus.disp_req = 1'b0;
    cyc(1'b0, 1'b0, "alt_tail");

    // Reset right after a display read grant drops its return.
    bus.disp_req  = 1'b1;
    bus.disp_addr = 16'h0005;
    cyc(1'b1, 1'b0, "pre_reset_rd");
    reset = 1'b1;
    sb.delete();
    cyc(1'b0, 1'b0, "mid_reset0");
    cyc(1'b0, 1'b0, "mid_reset1");
    reset         = 1'b0;
    bus.disp_addr = 16'h0006;
    cyc(1'b1, 1'b0, "post_reset_rd");
    bus.disp_req = 1'b0;
    cyc(1'b0, 1'b0, "post_reset_tail");
    cyc(1'b0, 1'b0, "final_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ava_vram_arbiter.md
# ava_vram_arbiter

Single-port VRAM arbiter that shares one VRAM port between the display pixel fetch path and the CPU bus. The display side (the direct-mode pixel fetch, which issues word addresses of 4 packed pixels) is real-time and wins by default. An optional starvation guard guarantees the CPU a slot. The block sits between the display pipeline/CPU bus interface and the VRAM macro, which has a 1-cycle synchronous read latency.

## Interface
- `STARVE_LIMIT`, default 8: consecutive denied CPU cycles before the CPU is forced through. Legal range 1..255; used only with the guard compiled in.

- `clk` in 1: system clock.
- `reset` in 1: reset is synchronous and active-high.
- `disp_req` in 1: display read request; held until granted.
- `disp_addr` in VRAM_ADDR_WIDTH: display word address.
- `disp_gnt` out 1: display access issued this cycle (combinational).
- `disp_rvalid` out 1: `disp_rdata` valid; one cycle after `disp_gnt`.
- `disp_rdata` out 32: read word.
- `cpu_req` in 1: CPU request; `cpu_we`, `cpu_addr`, `cpu_wdata`, `cpu_be` are held stable until granted.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in VRAM_ADDR_WIDTH: CPU word address.
- `cpu_wdata` in 32: write data.
- `cpu_be` in 4: byte enables (bit n = byte n).
- `cpu_gnt` out 1: CPU access issued this cycle (combinational); completes a write.
- `cpu_rvalid` out 1: `cpu_rdata` valid; one cycle after a read grant.
- `cpu_rdata` out 32: read word.
- `vram_a` out VRAM_ADDR_WIDTH: VRAM address.
- `vram_we` out 1: VRAM write strobe.
- `vram_be` out 4: VRAM byte enables.
- `vram_wd` out 32: VRAM write data.
- `vram_d` in 32: VRAM read data, valid the cycle after the address.

## Operation
- At most one VRAM access per cycle; a granted access is always issued in the same cycle.
- Winner selection:
  - Default: `disp_req` beats `cpu_req`.
  - With the guard forcing, the CPU wins instead.
  - A sole requester always wins.
- Return-owner register `owner_q`, an enum with values OWN_NONE, OWN_DISP and OWN_CPU:
  - Loaded each cycle with the granted read owner.
  - A CPU write or an idle cycle loads OWN_NONE.
- `vram_d` is routed to both `disp_rdata` and `cpu_rdata`. Only the rvalid matching `owner_q` asserts.
- When no access is issued:
  - `vram_we` = 0 and `vram_be` = 0.
  - `vram_a` holds its last value (registered mux select is not required; a combinational mux on the winner is used).
- `vram_we` = `cpu_gnt & cpu_we`. `vram_be` = `cpu_be` on a CPU write, 4'b0000 otherwise.
- Back-to-back grants to either side are allowed every cycle. Read data for cycle N's grant appears in cycle N+1 while cycle N+1's access is issued.

## Timing
- Grant latency: 0 cycles from `req` when winning.
- Read latency: `rvalid` exactly 1 cycle after `gnt`.
- Write latency: complete at `gnt`.
- Reset values:
  - `owner_q` = OWN_NONE; starvation counter = 0.
  - `disp_rvalid`, `cpu_rvalid` = 0.
  - `disp_gnt`, `cpu_gnt`, `vram_we`, `vram_be` = 0 while `reset` is high.
- Reset mid-operation: a read granted in the cycle before reset produces no `rvalid`. Requesters must re-request after reset.
- Dropping `req` before grant is illegal; behaviour is undefined.

## Configuration
- Macro: `AVA_VRAM_STARVE_GUARD_EN`.
- Defined (guard compiled in):
  - Counter `starve_q` (8 bit) increments each cycle with `cpu_req & ~cpu_gnt`, saturating at `STARVE_LIMIT`.
  - When `starve_q == STARVE_LIMIT`, the CPU wins regardless of `disp_req`.
  - `starve_q` clears on `cpu_gnt` or when `cpu_req` = 0.
- Undefined: strict display priority; the CPU may starve indefinitely; no counter logic is synthesized.

## Structure
- Additions to `ava_pkg`, next to the existing `VRAM_ADDR_WIDTH`:
  - typedef `vram_owner_t` (OWN_NONE, OWN_DISP, OWN_CPU).
  - constant `VRAM_BE_WIDTH` = 4.
- One sub-module: `ava_starve_guard` (counter plus force output, parameterized by `STARVE_LIMIT`). It is instantiated only under `AVA_VRAM_STARVE_GUARD_EN`.

## Test plan
- Only CPU write: `cpu_addr` 0x10, data 0xDEADBEEF, be 4'b0101 → `cpu_gnt` the same cycle, `vram_we` = 1, `vram_be` = 4'b0101, no `rvalid` next cycle.
- Only display reads to 0x00, 0x01, 0x02 on consecutive cycles:
  - `disp_gnt` held high.
  - `disp_rvalid` on cycles 1 to 3 with data from the VRAM model.
  - `cpu_rvalid` never asserts.
- Simultaneous `disp_req` + CPU read, guard off → display granted every cycle for 20 cycles and the CPU never granted. Drop `disp_req` → CPU granted the same cycle, `cpu_rvalid` the next.
- Guard on, `STARVE_LIMIT` = 3, both requesting continuously:
  - Grant pattern is D, D, D, C, repeating.
  - `starve_q` returns to 0 after each C.
- Reset asserted the cycle after a display read grant → no `disp_rvalid`; all outputs 0 during reset; the first grant follows the first non-reset cycle with `req`.
- Alternating CPU read (addr 0x20) and display read (addr 0x21) grants → each `rvalid` is routed to the correct side with the matching word.
